uart_rx_to_aes: RTL

Receive-side counterpart of the AES-to-UART transmit path. Deserializes 8N1 UART bytes from the `rx` pin, assembles 16 consecutive bytes into a 128-bit block, and presents the block to the downstream AES core with a valid/ready handshake. It also reports framing errors, overrun, and inter-byte timeout.

---
 rtl/uart_aes_pkg.sv | 22 ++
 rtl/uart_rx.sv | 107 ++++++++++
 rtl/uart_rx_to_aes.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_aes_pkg.sv
// Shared definitions for the UART <-> AES block transport (receive and transmit paths).
//   BLOCK_BYTES   : bytes per AES block
//   BLOCK_W       : block width in bits
//   rx_state_t    : receiver FSM states
//   clks_per_bit(): integer clock cycles per UART bit, truncated
package uart_aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver.
//   clk        in   system clock (rising edge)
//   reset      in   asynchronous active-low reset
//   rx         in   serial input, asynchronous, idles high
//   byte_valid out  one-cycle pulse, byte_data holds a good byte
//   byte_data  out  received byte (valid with byte_valid)
//   frame_err  out  one-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx
    import uart_aes_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CPB      = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT = CPB / 2;
    localparam int CNT_W    = $clog2(CPB);

    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // The shift register is not touched between stop sample and next frame,
    // so it doubles as the byte output.
    assign byte_data = shift_reg;

    // 2-FF synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= RX_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start-bit check; a line that is high again was a glitch.
                    if (cnt == CNT_W'(HALF_BIT - 1)) begin
                        cnt   <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt        <= '0;
                        byte_valid <= rx_s;
                        frame_err  <= !rx_s;
                        state      <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_to_aes.sv
// UART receive path feeding an AES core: assembles 16 bytes into a 128-bit block.
//   clk         in   system clock (rising edge)
//   reset       in   asynchronous active-low reset
//   rx          in   UART serial input
//   block_ready in   downstream accepts block_data
//   block_data  out  assembled block, first byte in [127:120]
//   block_valid out  block_data valid, held until accepted
//   byte_cnt    out  bytes in the current partial block
//   frame_err   out  pulse: stop bit low (partial block discarded)
//   overrun_err out  pulse: completed block dropped, output still occupied
//   timeout_err out  pulse: partial block discarded after an idle gap
module uart_rx_to_aes
    import uart_aes_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               block_ready,
    output logic [BLOCK_W-1:0] block_data,
    output logic               block_valid,
    output logic [3:0]         byte_cnt,
    output logic               frame_err,
    output logic               overrun_err,
    output logic               timeout_err
);

    localparam int CPB          = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CPB;
    localparam int GAP_W        = $clog2(TIMEOUT_CLKS + 1);

    logic               byte_valid;
    logic [7:0]         byte_data;
    // Only the first 15 bytes are stored; the 16th goes straight to the output.
    logic [BLOCK_W-9:0] asm_reg;
    logic [GAP_W-1:0]   gap_cnt;
    logic [BLOCK_W-1:0] full_block;
    logic               block_done;
    logic               take;
    logic               gap_expired;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign full_block  = {asm_reg, byte_data};
    assign block_done  = byte_valid && (byte_cnt == 4'(BLOCK_BYTES - 1));
    assign take        = block_valid && block_ready;
    assign gap_expired = (gap_cnt == GAP_W'(TIMEOUT_CLKS));

    // Assembler and inter-byte timeout. A byte always beats an expiring gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_reg     <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (frame_err) begin
                byte_cnt <= '0;
                gap_cnt  <= '0;
            end else if (byte_valid) begin
                for (int i = 0; i < BLOCK_BYTES - 1; i++) begin
                    if (byte_cnt == 4'(i)) begin
                        asm_reg[(BLOCK_BYTES - 2 - i) * 8 +: 8] <= byte_data;
                    end
                end
                byte_cnt <= byte_cnt + 4'd1;
                gap_cnt  <= '0;
            end else if (byte_cnt == 4'd0) begin
                gap_cnt <= '0;
            end else if (gap_expired) begin
                byte_cnt    <= '0;
                gap_cnt     <= '0;
                timeout_err <= 1'b1;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Output register: a block that arrives while an unaccepted one is held is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_data  <= '0;
            block_valid <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (block_done) begin
                if (!block_valid || take) begin
                    block_data  <= full_block;
                    block_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (take) begin
                block_valid <= 1'b0;
            end
        end
    end

endmodule
